// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_pkg
// Purpose  : Shared definitions for the multi-cycle MIPS main controller:
//            FSM state encodings, opcode/funct constants, ALU operation codes,
//            ALU B-source and PC-source select codes, instruction class type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mc_pkg;

    // State encodings; also exported on the debug 'state' output.
    typedef enum logic [3:0] {
        S_INIT      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC      = 4'd7,
        S_R_WB      = 4'd8,
        S_IMM_EXEC  = 4'd9,
        S_IMM_WB    = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_HILO_WB   = 4'd13
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] c_fn_div   = 6'h1A;
    localparam logic [5:0] c_fn_addu  = 6'h21;
    localparam logic [5:0] c_fn_subu  = 6'h23;
    localparam logic [5:0] c_fn_slt   = 6'h2A;

    // ALU operation codes
    localparam logic [2:0] c_alu_add  = 3'd0;
    localparam logic [2:0] c_alu_sub  = 3'd1;
    localparam logic [2:0] c_alu_or   = 3'd2;
    localparam logic [2:0] c_alu_div  = 3'd3;

    // ALU B-operand selects
    localparam logic [1:0] c_srcb_reg     = 2'b00;
    localparam logic [1:0] c_srcb_four    = 2'b01;
    localparam logic [1:0] c_srcb_imm     = 2'b10;
    localparam logic [1:0] c_srcb_imm_sh2 = 2'b11;

    // PC source selects
    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;

    // One-hot instruction class produced by the decoder
    typedef struct packed {
        logic mem;
        logic rtype;
        logic imm;
        logic branch;
        logic jump;
        logic div;
        logic illegal;
    } instr_class_t;

endpackage : mc_pkg
`default_nettype wire

// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_if
// Purpose  : Controller <-> datapath bundle. The instruction fields and ALU
//            flags flow into the controller; enables, mux selects and ALU
//            qualifiers flow out to the datapath.
// Modports : master - controller side (mc_ctrl)
//            slave  - datapath side
// Revision : 1.0 - initial release
// ============================================================================
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;

    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       ext_zero;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       slt;
    logic       addi;
    logic       hilo_write;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, funct, zero, overflow,
        output pc_write, pc_write_cond, i_or_d, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, ext_zero, alu_src_b, pc_source,
               alu_op, slt, addi, hilo_write, illegal, state
    );

    modport slave (
        output op, funct, zero, overflow,
        input  pc_write, pc_write_cond, i_or_d, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, ext_zero, alu_src_b, pc_source,
               alu_op, slt, addi, hilo_write, illegal, state
    );
endinterface : mc_ctrl_if
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// Module   : mc_decode
// Purpose  : Combinational op/funct -> one-hot instruction class.
// Ports    : op_i    [5:0] in  - IR[31:26]
//            funct_i [5:0] in  - IR[5:0]
//            class_o       out - one-hot class (mem, rtype, imm, branch,
//                                jump, div, illegal)
// Config   : MC_CTRL_DIV_EN - when defined funct 1A decodes as div,
//                             otherwise it is illegal.
// Revision : 1.0 - initial release
// ============================================================================
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0]   op_i,
    input  logic [5:0]   funct_i,
    output instr_class_t class_o
);

    always_comb begin
        class_o = '0;
        case (op_i)
            c_op_rtype: begin
                case (funct_i)
                    c_fn_addu, c_fn_subu, c_fn_slt: class_o.rtype = 1'b1;
`ifdef MC_CTRL_DIV_EN
                    c_fn_div:                       class_o.div   = 1'b1;
`endif
                    default:                        class_o.illegal = 1'b1;
                endcase
            end
            c_op_lw, c_op_sw:     class_o.mem    = 1'b1;
            c_op_addi, c_op_ori:  class_o.imm    = 1'b1;
            c_op_beq:             class_o.branch = 1'b1;
            c_op_j:               class_o.jump   = 1'b1;
            default:              class_o.illegal = 1'b1;
        endcase
    end

endmodule : mc_decode
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Main control FSM of the multi-cycle MIPS datapath. Sequences
//            FETCH -> DECODE -> class-specific states and drives all datapath
//            enables, mux selects and ALU qualifiers as Moore outputs.
// Ports    : clk   in  - rising-edge clock
//            reset in  - synchronous, active-high
//            bus       - mc_ctrl_if.master (instruction fields, ALU flags in;
//                        control outputs and debug state out)
// Config   : MC_CTRL_DIV_EN - enables div (funct 1A): EXEC drives alu_op=3
//            and HILO_WB becomes reachable. Undefined: hilo_write tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    mc_ctrl_if.master   bus
);

    state_t       state_q;
    logic         ov_q;     // addi overflowed: suppress the write-back
    logic         ori_q;    // instruction in IMM_WB is ori: keep zero-extend
    instr_class_t cls;

    mc_decode u_decode (
        .op_i    (bus.op),
        .funct_i (bus.funct),
        .class_o (cls)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
            ov_q    <= 1'b0;
            ori_q   <= 1'b0;
        end else begin
            case (state_q)
                S_INIT:   state_q <= S_FETCH;
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    if (cls.mem)                     state_q <= S_MEM_ADDR;
                    else if (cls.rtype || cls.div)   state_q <= S_EXEC;
                    else if (cls.imm)                state_q <= S_IMM_EXEC;
                    else if (cls.branch)             state_q <= S_BRANCH;
                    else if (cls.jump)               state_q <= S_JUMP;
                    else                             state_q <= S_FETCH;
                end
                S_MEM_ADDR: state_q <= (bus.op == c_op_lw) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ: state_q <= S_MEM_WB;
                S_EXEC: begin
`ifdef MC_CTRL_DIV_EN
                    state_q <= cls.div ? S_HILO_WB : S_R_WB;
`else
                    state_q <= S_R_WB;
`endif
                end
                S_IMM_EXEC: begin
                    // Only point where the overflow flag is observed.
                    ov_q    <= bus.overflow & (bus.op == c_op_addi);
                    ori_q   <= (bus.op == c_op_ori);
                    state_q <= S_IMM_WB;
                end
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    // Moore output decode; pc_write_cond is qualified by zero in the datapath.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.ext_zero      = 1'b0;
        bus.alu_src_b     = c_srcb_reg;
        bus.pc_source     = c_pcsrc_alu;
        bus.alu_op        = c_alu_add;
        bus.slt           = 1'b0;
        bus.addi          = 1'b0;
        bus.hilo_write    = 1'b0;
        bus.illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.ir_write  = 1'b1;
                bus.pc_write  = 1'b1;
                bus.alu_src_b = c_srcb_four;
            end
            S_DECODE: begin
                bus.alu_src_b = c_srcb_imm_sh2;   // branch target into ALUOut
                bus.illegal   = cls.illegal;
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = c_srcb_imm;
            end
            S_MEM_READ:  bus.i_or_d = 1'b1;
            S_MEM_WB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                bus.i_or_d    = 1'b1;
                bus.mem_write = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                if (cls.div) begin
                    bus.alu_op = c_alu_div;
                end else if (bus.funct == c_fn_subu) begin
                    bus.alu_op = c_alu_sub;
                end else if (bus.funct == c_fn_slt) begin
                    bus.alu_op = c_alu_sub;
                    bus.slt    = 1'b1;
                end
            end
            S_R_WB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
            end
            S_IMM_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = c_srcb_imm;
                if (bus.op == c_op_ori) begin
                    bus.alu_op   = c_alu_or;
                    bus.ext_zero = 1'b1;
                end else begin
                    bus.addi = 1'b1;
                end
            end
            S_IMM_WB: begin
                bus.reg_write = ~ov_q;
                bus.ext_zero  = ori_q;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = c_alu_sub;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = c_pcsrc_aluout;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = c_pcsrc_jump;
            end
`ifdef MC_CTRL_DIV_EN
            S_HILO_WB:   bus.hilo_write = 1'b1;
`endif
            default: ;
        endcase
    end

    assign bus.state = state_q;

endmodule : mc_ctrl
`default_nettype wire
